// File: rtl/pdm_rx.sv
// PDM mic receiver: pdm_clk divider, 2-flop sync, 3rd-order CIC decimator, PCM FIFO, 8-bit register port.
// Latency: sample pushed 2 clk after the decim strobe; dout 1 clk after a read.
// Backpressure: none upstream; FIFO push when full drops the sample and sets sticky overflow.
module fifo #(
   parameter int DW = 16,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          wr_vld,
   input  logic [DW-1:0] wr_dat,
   output logic          full,
   input  logic          rd_rdy,
   output logic          rd_vld,
   output logic [DW-1:0] rd_dat,
   output logic [AW:0]   level
);
   localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

   logic [DW-1:0] mem_q [2**AW];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_wr, do_rd;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
   always_comb begin
      do_rd    = rd_rdy && (cnt_q != '0);
      do_wr    = wr_vld && !flush && ((cnt_q != DEPTH) || do_rd);
      wr_ptr_d = wr_ptr_q + AW'(do_wr);
      rd_ptr_d = rd_ptr_q + AW'(do_rd);
      cnt_d    = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
   end

   assign full   = (cnt_q == DEPTH);
   assign rd_vld = (cnt_q != '0);
   assign rd_dat = mem_q[rd_ptr_q];
   assign level  = cnt_q;
endmodule

module pdm_rx #(
   parameter int CLK_DIV = 8,
   parameter int DEC_R   = 64,
   parameter int FIFO_AW = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       we,
   input  logic [2:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irq,
   output logic       pdm_clk,
   input  logic       pdm_dat
);
   localparam int CW  = $clog2(CLK_DIV);
   localparam int DCW = $clog2(DEC_R);
   localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]  CNT_LOW  = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0]  CNT_HIGH = CW'(CLK_DIV / 2);
   localparam logic [DCW-1:0] DEC_LAST = DCW'(DEC_R - 1);

   typedef struct packed {
      logic irq_en;
      logic edge_sel;
      logic enable;
   } ctrl_t;

   ctrl_t                ctrl_q, ctrl_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 pdm_clk_q, pdm_clk_d;
   logic [1:0]           sync_q, sync_d;
   logic signed [19:0]   int1_q, int1_d, int2_q, int2_d, int3_q, int3_d;
   logic signed [19:0]   dly1_q, dly1_d, dly2_q, dly2_d, dly3_q, dly3_d;
   logic signed [19:0]   comb_q, comb_d;
   logic [DCW-1:0]       dec_q, dec_d;
   logic                 dec_p1_q, dec_p1_d, dec_p2_q, dec_p2_d;
   logic [1:0]           disc_q, disc_d;
   logic                 ovf_q, ovf_d;
   logic [7:0]           hold_q, hold_d, dout_q, dout_d;

   logic                 rd_acc, ctrl_wr, stat_wr, flush, en_next, run, strobe, decim;
   logic                 pop, push_vld, fifo_full, fifo_vld;
   logic [15:0]          fifo_dat, pcm;
   logic [FIFO_AW:0]     fifo_lvl;
   logic signed [19:0]   x, c1, c2, y;
   logic                 unused_din;

   assign unused_din = ^din[6:3];

   // en_next lets a CTRL write that clears enable stop pdm_clk on the very edge it lands.
   always_comb begin
      rd_acc   = cs && !we;
      ctrl_wr  = cs && we && (addr == 3'd0);
      stat_wr  = cs && we && (addr == 3'd1);
      flush    = ctrl_wr && din[7];
      en_next  = ctrl_wr ? din[0] : ctrl_q.enable;
      run      = en_next && ctrl_q.enable;
      strobe   = run && (cnt_q == (ctrl_q.edge_sel ? CNT_LAST : CNT_LOW));
      decim    = strobe && (dec_q == DEC_LAST);
      pop      = rd_acc && (addr == 3'd2) && fifo_vld;
      push_vld = run && dec_p2_q && (disc_q == 2'd3);
      y        = comb_q >>> 3;
      if (y > 20'sd32767)       pcm = 16'h7FFF;
      else if (y < -20'sd32768) pcm = 16'h8000;
      else                      pcm = y[15:0];
   end

   always_comb begin
      ctrl_d    = ctrl_q;
      cnt_d     = cnt_q;
      pdm_clk_d = pdm_clk_q;
      sync_d    = {sync_q[0], pdm_dat};
      int1_d    = int1_q;
      int2_d    = int2_q;
      int3_d    = int3_q;
      dly1_d    = dly1_q;
      dly2_d    = dly2_q;
      dly3_d    = dly3_q;
      comb_d    = comb_q;
      dec_d     = dec_q;
      dec_p1_d  = dec_p1_q;
      dec_p2_d  = dec_p2_q;
      disc_d    = disc_q;
      ovf_d     = ovf_q;
      hold_d    = hold_q;
      dout_d    = dout_q;
      x         = '0;
      c1        = '0;
      c2        = '0;

      if (ctrl_wr) ctrl_d = ctrl_t'(din[2:0]);
      if (stat_wr && din[2]) ovf_d = 1'b0;
      if (push_vld && fifo_full && !pop && !flush) ovf_d = 1'b1;

      if (rd_acc) begin
         case (addr)
            3'd0:    dout_d = {5'b0, ctrl_q};
            3'd1:    dout_d = {5'b0, ovf_q, fifo_full, fifo_vld};
            3'd2: begin
               dout_d = fifo_vld ? fifo_dat[7:0] : 8'h00;
               if (fifo_vld) hold_d = fifo_dat[15:8];
            end
            3'd3:    dout_d = hold_q;
            3'd4:    dout_d = 8'(fifo_lvl);
            default: dout_d = 8'h00;
         endcase
      end

      if (!run) begin
         cnt_d     = '0;
         pdm_clk_d = 1'b0;
         int1_d    = '0;
         int2_d    = '0;
         int3_d    = '0;
         dly1_d    = '0;
         dly2_d    = '0;
         dly3_d    = '0;
         comb_d    = '0;
         dec_d     = '0;
         dec_p1_d  = 1'b0;
         dec_p2_d  = 1'b0;
         disc_d    = '0;
      end else begin
         cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
         pdm_clk_d = (cnt_d >= CNT_HIGH);
         if (strobe) begin
            x      = sync_q[1] ? 20'sd1 : -20'sd1;
            int1_d = int1_q + x;
            int2_d = int2_q + int1_d;
            int3_d = int3_q + int2_d;
            dec_d  = dec_q + 1'b1;
         end
         dec_p1_d = decim;
         dec_p2_d = dec_p1_q;
         if (dec_p1_q) begin
            c1     = int3_q - dly1_q;
            c2     = c1 - dly2_q;
            dly1_d = int3_q;
            dly2_d = c1;
            dly3_d = c2;
            comb_d = c2 - dly3_q;
         end
         // The first three decimated outputs carry the CIC start-up transient.
         if (dec_p2_q && disc_q != 2'd3) disc_d = disc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_q    <= '0;
         cnt_q     <= '0;
         pdm_clk_q <= 1'b0;
         sync_q    <= '0;
         int1_q    <= '0;
         int2_q    <= '0;
         int3_q    <= '0;
         dly1_q    <= '0;
         dly2_q    <= '0;
         dly3_q    <= '0;
         comb_q    <= '0;
         dec_q     <= '0;
         dec_p1_q  <= 1'b0;
         dec_p2_q  <= 1'b0;
         disc_q    <= '0;
         ovf_q     <= 1'b0;
         hold_q    <= '0;
         dout_q    <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         cnt_q     <= cnt_d;
         pdm_clk_q <= pdm_clk_d;
         sync_q    <= sync_d;
         int1_q    <= int1_d;
         int2_q    <= int2_d;
         int3_q    <= int3_d;
         dly1_q    <= dly1_d;
         dly2_q    <= dly2_d;
         dly3_q    <= dly3_d;
         comb_q    <= comb_d;
         dec_q     <= dec_d;
         dec_p1_q  <= dec_p1_d;
         dec_p2_q  <= dec_p2_d;
         disc_q    <= disc_d;
         ovf_q     <= ovf_d;
         hold_q    <= hold_d;
         dout_q    <= dout_d;
      end
   end

   fifo #(.DW(16), .AW(FIFO_AW)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .wr_vld (push_vld),
      .wr_dat (pcm),
      .full   (fifo_full),
      .rd_rdy (pop),
      .rd_vld (fifo_vld),
      .rd_dat (fifo_dat),
      .level  (fifo_lvl)
   );

   assign dout    = dout_q;
   assign irq     = ctrl_q.irq_en & fifo_vld;
   assign pdm_clk = pdm_clk_q;
endmodule

// File: tb/tb_pdm_rx.sv
// Directed bench for pdm_rx: divider waveform, CIC saturation/zero outputs, FIFO full/overflow/flush, async reset.
module tb_pdm_rx;
   logic       clk = 1'b0;
   logic       rst, cs, we;
   logic [2:0] addr;
   logic [7:0] din, dout;
   logic       irq, pdm_clk, pdm_dat;
   logic       dat_lvl, alt_on, alt_bit;
   int         n_cmp = 0;
   int         n_bad = 0;

   assign pdm_dat = alt_on ? alt_bit : dat_lvl;
   always #5 clk = ~clk;

   pdm_rx dut (
      .clk     (clk),
      .rst     (rst),
      .cs      (cs),
      .we      (we),
      .addr    (addr),
      .din     (din),
      .dout    (dout),
      .irq     (irq),
      .pdm_clk (pdm_clk),
      .pdm_dat (pdm_dat)
   );

   initial begin
      alt_bit = 1'b0;
      forever begin
         @(posedge pdm_clk);
         alt_bit = ~alt_bit;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
      cs = 1'b1; we = 1'b1; addr = a; din = d;
      @(posedge clk); #1;
      cs = 1'b0; we = 1'b0; din = 8'h00;
   endtask

   task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
      cs = 1'b1; we = 1'b0; addr = a;
      @(posedge clk); #1;
      cs = 1'b0;
      d = dout;
   endtask

   task automatic wait_irq(input int bound, output int k);
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!irq && k < bound);
   endtask

   task automatic wait_pclk_hi(input int bound);
      int k = 0;
      while (!pdm_clk && k < bound) begin
         @(posedge clk); #1;
         k++;
      end
   endtask

   logic [7:0]  rd;
   logic [15:0] pat;
   int          k;

   initial begin
      rst = 1'b0; cs = 1'b0; we = 1'b0; addr = 3'd0; din = 8'h00;
      dat_lvl = 1'b1; alt_on = 1'b0;
      #8;
      chk("rst_dout", dout, 8'h00);
      chk("rst_irq", irq, 1'b0);
      chk("rst_pclk", pdm_clk, 1'b0);
      #4 rst = 1'b1;
      @(posedge clk); #1;

      // constant 1: divider waveform, first-push latency, positive saturation
      bus_wr(3'd0, 8'h05);
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         pat[i] = pdm_clk;
      end
      chk("pclk_wave", pat, 16'h7878);
      wait_irq(3000, k);
      chk("lat_edge0", 16 + k, 2046);
      bus_rd(3'd2, rd); chk("dlo_pos", rd, 8'hFF);
      bus_rd(3'd3, rd); chk("dhi_pos", rd, 8'h7F);
      bus_rd(3'd4, rd); chk("lvl_after_pop", rd, 8'h00);
      wait_irq(600, k); chk("irq_2nd", irq, 1'b1);
      bus_rd(3'd2, rd); chk("dlo_pos2", rd, 8'hFF);
      wait_pclk_hi(16);
      chk("pclk_hi_pre", pdm_clk, 1'b1);
      bus_wr(3'd0, 8'h04);
      chk("pclk_stop", pdm_clk, 1'b0);
      repeat (10) @(posedge clk);
      #1 chk("pclk_stays", pdm_clk, 1'b0);

      // constant 0: negative full scale, empty-read behaviour
      dat_lvl = 1'b0;
      bus_wr(3'd0, 8'h05);
      wait_irq(3000, k); chk("irq_neg", irq, 1'b1);
      bus_rd(3'd2, rd); chk("dlo_neg", rd, 8'h00);
      bus_rd(3'd3, rd); chk("dhi_neg", rd, 8'h80);
      bus_rd(3'd2, rd); chk("dlo_empty", rd, 8'h00);
      bus_rd(3'd3, rd); chk("dhi_hold", rd, 8'h80);
      bus_rd(3'd4, rd); chk("lvl_empty", rd, 8'h00);
      bus_wr(3'd0, 8'h00);

      // alternating input sampled at end of high phase: zero output
      alt_on = 1'b1;
      bus_wr(3'd0, 8'h07);
      wait_irq(3000, k);
      chk("lat_edge1", k, 2050);
      bus_rd(3'd2, rd); chk("dlo_alt", rd, 8'h00);
      bus_rd(3'd3, rd); chk("dhi_alt", rd, 8'h00);
      bus_wr(3'd0, 8'h03);
      repeat (600) @(posedge clk);
      #1 chk("irq_masked", irq, 1'b0);
      bus_rd(3'd4, rd); chk("lvl_alt", rd, 8'h01);
      bus_rd(3'd2, rd); chk("dlo_alt2", rd, 8'h00);
      bus_wr(3'd0, 8'h00);
      alt_on = 1'b0;

      // fill to 17 pushes with no reads, then drain
      dat_lvl = 1'b1;
      bus_wr(3'd0, 8'h05);
      wait_irq(3000, k); chk("irq_fill", irq, 1'b1);
      repeat (16 * 512 + 100) @(posedge clk);
      #1 bus_wr(3'd0, 8'h00);
      bus_rd(3'd4, rd); chk("lvl_full", rd, 8'h10);
      bus_rd(3'd1, rd); chk("stat_ovf", rd, 8'h07);
      bus_wr(3'd1, 8'h04);
      bus_rd(3'd1, rd); chk("stat_clr", rd, 8'h03);
      for (int i = 0; i < 16; i++) begin
         bus_rd(3'd2, rd);
         chk($sformatf("drain%0d", i), rd, 8'hFF);
      end
      bus_rd(3'd2, rd); chk("drain16", rd, 8'h00);
      bus_rd(3'd4, rd); chk("lvl_drained", rd, 8'h00);
      bus_rd(3'd1, rd); chk("stat_drained", rd, 8'h00);

      // flush at level 5, then async reset mid-conversion
      bus_wr(3'd0, 8'h05);
      wait_irq(3000, k); chk("irq_flush", irq, 1'b1);
      repeat (4 * 512 + 50) @(posedge clk);
      #1 bus_rd(3'd4, rd); chk("lvl5", rd, 8'h05);
      bus_wr(3'd0, 8'h85);
      bus_rd(3'd4, rd); chk("lvl_flushed", rd, 8'h00);
      bus_rd(3'd0, rd); chk("ctrl_b7", rd, 8'h05);
      wait_irq(600, k); chk("irq_post_flush", irq, 1'b1);
      bus_rd(3'd1, rd); chk("stat_post_flush", rd, 8'h01);
      wait_pclk_hi(16);
      chk("pclk_hi_rst", pdm_clk, 1'b1);
      #3 rst = 1'b0;
      #1;
      chk("arst_pclk", pdm_clk, 1'b0);
      chk("arst_irq", irq, 1'b0);
      chk("arst_dout", dout, 8'h00);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      bus_rd(3'd0, rd); chk("ctrl_after_rst", rd, 8'h00);
      bus_rd(3'd4, rd); chk("lvl_after_rst", rd, 8'h00);
      bus_rd(3'd1, rd); chk("stat_after_rst", rd, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
